// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the RV32I core.
// Owns every stall, bubble and flush decision for IF/ID, ID/EX and EX/MEM.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_rs1_used,
  input  logic             ifid_rs2_used,
  input  logic [4:0]       idex_rd,
  input  logic             idex_mem_read,
  input  logic             ex_mispredict,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2,
    MWAIT  = 2'd3
  } state_e;

  localparam logic [3:0] LSC_L = 4'(LOAD_STALL_CYCLES);
  localparam logic [3:0] FC_L  = 4'(FLUSH_CYCLES);
  localparam logic [2:0] LSC_1 = (LOAD_STALL_CYCLES > 1) ? 3'd1 : 3'd0;
  localparam logic [2:0] FC_1  = (FLUSH_CYCLES > 1) ? 3'd1 : 3'd0;
  localparam state_e     LS_NX = (LOAD_STALL_CYCLES > 1) ? LSTALL : RUN;
  localparam state_e     FL_NX = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_q;

  logic       hz, mp;
  logic [3:0] cnt_inc;
  logic       pc_c, ifid_c, idex_c, exmem_c;
  logic       ifl_c, idfl_c;

  assign hz = idex_mem_read && (idex_rd != 5'd0) &&
              ((ifid_rs1_used && (ifid_rs1 == idex_rd)) ||
               (ifid_rs2_used && (ifid_rs2 == idex_rd)));

  // A mispredict parked during a memory wait is replayed as a fresh one.
  assign mp = ex_mispredict || ((state_q == MWAIT) && pend_q);

  assign cnt_inc = {1'b0, cnt_q} + 4'd1;

  // Next-state and stage controls, priority mem_busy > mispredict > load-use.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pc_c    = 1'b1;
    ifid_c  = 1'b1;
    idex_c  = 1'b1;
    exmem_c = 1'b1;
    ifl_c   = 1'b0;
    idfl_c  = 1'b0;
    if (mem_busy) begin
      pc_c    = 1'b0;
      ifid_c  = 1'b0;
      idex_c  = 1'b0;
      exmem_c = 1'b0;
      pend_d  = mp;
      cnt_d   = 3'd0;
      state_d = MWAIT;
    end else if (mp) begin
      ifl_c   = 1'b1;
      idfl_c  = 1'b1;
      pend_d  = 1'b0;
      cnt_d   = FC_1;
      state_d = FL_NX;
    end else begin
      unique case (state_q)
        FLUSH: begin
          ifl_c  = 1'b1;
          idfl_c = 1'b1;
          if (cnt_inc >= FC_L) begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_inc[2:0];
          end
        end
        LSTALL: begin
          pc_c   = 1'b0;
          ifid_c = 1'b0;
          idfl_c = 1'b1;
          if (cnt_inc >= LSC_L) begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_inc[2:0];
          end
        end
        default: begin
          if (hz) begin
            pc_c    = 1'b0;
            ifid_c  = 1'b0;
            idfl_c  = 1'b1;
            cnt_d   = LSC_1;
            state_d = LS_NX;
          end else begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end
        end
      endcase
    end
  end

  // State, stall-length counter and parked mispredict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_c && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign pc_en       = pc_c & ~rst;
  assign ifid_en     = ifid_c & ~rst;
  assign idex_en     = idex_c & ~rst;
  assign exmem_en    = exmem_c & ~rst;
  assign ifid_flush  = ifl_c & ~rst;
  assign idex_flush  = idfl_c & ~rst;
  assign ctrl_state  = state_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Instance a uses default parameters, instance b LSC=3, FC=2, CNT_W=3.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] RUNV = 6'b111100;
  localparam logic [5:0] HZV  = 6'b001101;
  localparam logic [5:0] MPV  = 6'b111111;
  localparam logic [5:0] ZV   = 6'b000000;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [4:0] rs1, rs2, rd;
  logic rs1_u, rs2_u, mrd, mp, busy;

  logic pc_a, ifid_a, idex_a, exmem_a, ifl_a, idfl_a;
  logic pc_b, ifid_b, idex_b, exmem_b, ifl_b, idfl_b;
  logic [1:0] st_a, st_b;
  logic [15:0] cnt_a;
  logic [2:0] cnt_b;
  logic [5:0] oa, ob;

  int checks = 0;
  int fails = 0;

  assign oa = {pc_a, ifid_a, idex_a, exmem_a, ifl_a, idfl_a};
  assign ob = {pc_b, ifid_b, idex_b, exmem_b, ifl_b, idfl_b};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_a (
    .clk(clk), .rst(rst_a),
    .ifid_rs1(rs1), .ifid_rs2(rs2),
    .ifid_rs1_used(rs1_u), .ifid_rs2_used(rs2_u),
    .idex_rd(rd), .idex_mem_read(mrd),
    .ex_mispredict(mp), .mem_busy(busy),
    .pc_en(pc_a), .ifid_en(ifid_a),
    .idex_en(idex_a), .exmem_en(exmem_a),
    .ifid_flush(ifl_a), .idex_flush(idfl_a),
    .ctrl_state(st_a), .stall_count(cnt_a)
  );

  pipeline_hazard_ctrl #(
    .LOAD_STALL_CYCLES(3),
    .FLUSH_CYCLES(2),
    .CNT_W(3)
  ) u_b (
    .clk(clk), .rst(rst_b),
    .ifid_rs1(rs1), .ifid_rs2(rs2),
    .ifid_rs1_used(rs1_u), .ifid_rs2_used(rs2_u),
    .idex_rd(rd), .idex_mem_read(mrd),
    .ex_mispredict(mp), .mem_busy(busy),
    .pc_en(pc_b), .ifid_en(ifid_b),
    .idex_en(idex_b), .exmem_en(exmem_b),
    .ifid_flush(ifl_b), .idex_flush(idfl_b),
    .ctrl_state(st_b), .stall_count(cnt_b)
  );

  task automatic drv(input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic [4:0] d, input logic ld,
                     input logic m, input logic b);
    rs1 = r1; rs1_u = u1; rs2 = r2; rs2_u = u2;
    rd = d; mrd = ld; mp = m; busy = b;
  endtask

  task automatic idle();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst_b();
    idle();
    rst_b = 1'b1;
    nxt();
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_a = 1'b1;
    rst_b = 1'b1;
    nxt(); nxt();
    #4;
    checks++;
    if (oa !== ZV) begin
      fails++; $display("FAIL rst_out got=%b exp=%b", oa, ZV);
    end
    checks++;
    if (st_a !== 2'd0 || cnt_a !== 16'd0) begin
      fails++; $display("FAIL rst_state got=%0d/%0d exp=0/0", st_a, cnt_a);
    end
    nxt();
    rst_a = 1'b0;
    rst_b = 1'b0;
    #4;
    checks++;
    if (oa !== RUNV) begin
      fails++; $display("FAIL post_rst got=%b exp=%b", oa, RUNV);
    end
    nxt();
  endtask

  task automatic test_load_use();
    drv(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (oa !== HZV || st_a !== 2'd0) begin
      fails++; $display("FAIL lu_rs1 got=%b/%0d exp=%b/0", oa, st_a, HZV);
    end
    nxt();
    idle();
    #4;
    checks++;
    if (oa !== RUNV || cnt_a !== 16'd1) begin
      fails++; $display("FAIL lu_rel got=%b/%0d exp=%b/1", oa, cnt_a, RUNV);
    end
    nxt();
    drv(5'd2, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (oa !== HZV) begin
      fails++; $display("FAIL lu_rs2 got=%b exp=%b", oa, HZV);
    end
    nxt();
    drv(5'd2, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (oa !== RUNV) begin
      fails++; $display("FAIL lu_unused got=%b exp=%b", oa, RUNV);
    end
    nxt();
  endtask

  task automatic test_x0();
    drv(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (oa !== RUNV) begin
      fails++; $display("FAIL x0 got=%b exp=%b", oa, RUNV);
    end
    nxt();
    drv(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    #4;
    checks++;
    if (oa !== RUNV || cnt_a !== 16'd2) begin
      fails++; $display("FAIL noload got=%b/%0d exp=%b/2", oa, cnt_a, RUNV);
    end
    nxt();
  endtask

  task automatic test_flush();
    pulse_rst_b();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #4;
    checks++;
    if (ob !== MPV || oa !== MPV) begin
      fails++; $display("FAIL fl_c1 got=%b/%b exp=%b", ob, oa, MPV);
    end
    nxt();
    idle();
    #4;
    checks++;
    if (ob !== MPV || st_b !== 2'd2) begin
      fails++; $display("FAIL fl_c2 got=%b/%0d exp=%b/2", ob, st_b, MPV);
    end
    checks++;
    if (oa !== RUNV) begin
      fails++; $display("FAIL fl_a2 got=%b exp=%b", oa, RUNV);
    end
    nxt();
    #4;
    checks++;
    if (ob !== RUNV || st_b !== 2'd0) begin
      fails++; $display("FAIL fl_end got=%b/%0d exp=%b/0", ob, st_b, RUNV);
    end
    nxt();
  endtask

  task automatic test_mwait();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    #4;
    checks++;
    if (oa !== ZV) begin
      fails++; $display("FAIL mw_c1 got=%b exp=%b", oa, ZV);
    end
    nxt();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #4;
    checks++;
    if (oa !== ZV || st_a !== 2'd3) begin
      fails++; $display("FAIL mw_c2 got=%b/%0d exp=%b/3", oa, st_a, ZV);
    end
    nxt();
    #4;
    checks++;
    if (oa !== ZV) begin
      fails++; $display("FAIL mw_c3 got=%b exp=%b", oa, ZV);
    end
    nxt();
    idle();
    #4;
    checks++;
    if (oa !== MPV || st_a !== 2'd3) begin
      fails++; $display("FAIL mw_replay got=%b/%0d exp=%b/3", oa, st_a, MPV);
    end
    nxt();
    #4;
    checks++;
    if (oa !== RUNV || cnt_a !== 16'd5) begin
      fails++; $display("FAIL mw_end got=%b/%0d exp=%b/5", oa, cnt_a, RUNV);
    end
    nxt();
  endtask

  task automatic test_hz_busy();
    drv(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    #4;
    checks++;
    if (oa !== ZV) begin
      fails++; $display("FAIL hb_c1 got=%b exp=%b", oa, ZV);
    end
    nxt();
    drv(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (oa !== HZV || st_a !== 2'd3) begin
      fails++; $display("FAIL hb_c2 got=%b/%0d exp=%b/3", oa, st_a, HZV);
    end
    nxt();
    idle();
    #4;
    checks++;
    if (oa !== RUNV || cnt_a !== 16'd7) begin
      fails++; $display("FAIL hb_end got=%b/%0d exp=%b/7", oa, cnt_a, RUNV);
    end
    nxt();
  endtask

  task automatic test_back_to_back();
    drv(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (oa !== HZV) begin
      fails++; $display("FAIL b2b_1 got=%b exp=%b", oa, HZV);
    end
    nxt();
    drv(5'd1, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (oa !== HZV) begin
      fails++; $display("FAIL b2b_2 got=%b exp=%b", oa, HZV);
    end
    nxt();
    idle();
    #4;
    checks++;
    if (oa !== RUNV || cnt_a !== 16'd9) begin
      fails++; $display("FAIL b2b_end got=%b/%0d exp=%b/9", oa, cnt_a, RUNV);
    end
    nxt();
  endtask

  task automatic test_preempt();
    pulse_rst_b();
    drv(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (ob !== HZV) begin
      fails++; $display("FAIL pre_hz got=%b exp=%b", ob, HZV);
    end
    nxt();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #4;
    checks++;
    if (ob !== MPV || st_b !== 2'd1) begin
      fails++; $display("FAIL pre_mp got=%b/%0d exp=%b/1", ob, st_b, MPV);
    end
    nxt();
    idle();
    #4;
    checks++;
    if (ob !== MPV || st_b !== 2'd2) begin
      fails++; $display("FAIL pre_fl got=%b/%0d exp=%b/2", ob, st_b, MPV);
    end
    nxt();
    #4;
    checks++;
    if (ob !== RUNV || cnt_b !== 3'd1) begin
      fails++; $display("FAIL pre_end got=%b/%0d exp=%b/1", ob, cnt_b, RUNV);
    end
    nxt();
  endtask

  task automatic test_rst_lstall();
    pulse_rst_b();
    drv(5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    #4;
    checks++;
    if (ob !== HZV) begin
      fails++; $display("FAIL rl_c1 got=%b exp=%b", ob, HZV);
    end
    nxt();
    idle();
    #4;
    checks++;
    if (ob !== HZV || st_b !== 2'd1) begin
      fails++; $display("FAIL rl_c2 got=%b/%0d exp=%b/1", ob, st_b, HZV);
    end
    nxt();
    #4;
    checks++;
    if (st_b !== 2'd1 || cnt_b !== 3'd2) begin
      fails++; $display("FAIL rl_c3 got=%0d/%0d exp=1/2", st_b, cnt_b);
    end
    rst_b = 1'b1;
    #1;
    checks++;
    if (st_b !== 2'd0 || cnt_b !== 3'd0 || ob !== ZV) begin
      fails++;
      $display("FAIL rl_async got=%0d/%0d/%b exp=0/0/%b", st_b, cnt_b, ob, ZV);
    end
    nxt();
    rst_b = 1'b0;
    #4;
    checks++;
    if (ob !== RUNV) begin
      fails++; $display("FAIL rl_after got=%b exp=%b", ob, RUNV);
    end
    nxt();
  endtask

  task automatic test_saturate();
    pulse_rst_b();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) nxt();
    #4;
    checks++;
    if (cnt_b !== 3'd6) begin
      fails++; $display("FAIL sat_mid got=%0d exp=6", cnt_b);
    end
    for (int i = 0; i < 3; i++) nxt();
    idle();
    #4;
    checks++;
    if (cnt_b !== 3'd7 || ob !== RUNV) begin
      fails++; $display("FAIL sat_end got=%0d/%b exp=7/%b", cnt_b, ob, RUNV);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_flush();
    test_mwait();
    test_hz_busy();
    test_back_to_back();
    test_preempt();
    test_rst_lstall();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
